// File: rtl/icache_inv_issuer.sv
// ---------------------------------------------------------------------------
// icache_inv_issuer
//
// Initiator side of the instruction-cache external-invalidation handshake.
// Line-granular invalidation requests from a snoop source are buffered in a
// small circular FIFO. They are issued one at a time on extern_inv/inv_addr,
// and each request is held until extern_inv_complete, which pops it.
//
// Optional feature, selected by the macro ICACHE_INV_MERGE_EN:
//   defined   - a snoop whose line already sits in a valid queue entry is
//               absorbed instead of occupying a new entry. The in-flight
//               head entry is excluded from this match.
//   undefined - no comparators are built; every accepted request gets its
//               own entry.
//
// Parameters:
//   DEPTH          FIFO entries (power of two, >= 2)
//   LINE_OFFSET_W  log2 bytes per I-cache line
//
// Ports:
//   clk                  in   core clock
//   rst_n                in   asynchronous active-low reset
//   snoop_valid          in   invalidation request present
//   snoop_addr[31:0]     in   byte address written (offset bits ignored)
//   snoop_ready          out  request accepted when valid & ready
//   extern_inv           out  invalidation request to I-cache tag banks
//   inv_addr[31:0]       out  line-aligned address of the current request
//   extern_inv_complete  in   I-cache finished the current invalidation
//   inv_pending          out  queue holds at least one request
// ---------------------------------------------------------------------------
module icache_inv_issuer #(
    parameter int DEPTH         = 4,
    parameter int LINE_OFFSET_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snoop_valid,
    input  logic [31:0] snoop_addr,
    output logic        snoop_ready,
    output logic        extern_inv,
    output logic [31:0] inv_addr,
    input  logic        extern_inv_complete,
    output logic        inv_pending
);

    localparam int LINE_W = 32 - LINE_OFFSET_W;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [LINE_W-1:0]  r_lines [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [LINE_W-1:0]  r_inv_line;

    logic [LINE_W-1:0]  w_snoop_line;
    logic               w_merge_hit;
    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_load_addr;
    logic               w_unused_offset;

    assign w_snoop_line    = snoop_addr[31:LINE_OFFSET_W];
    assign w_unused_offset = ^snoop_addr[LINE_OFFSET_W-1:0];

`ifdef ICACHE_INV_MERGE_EN
    // A snoop merges into any valid entry holding the same line, except the
    // head while it is being issued: the tag read for that line may already
    // have happened, so a new write to it must be invalidated again.
    logic [DEPTH-1:0] w_hit;

    for (genvar g = 0; g < DEPTH; g++) begin : g_merge_cmp
        logic [PTR_W-1:0] w_offset;
        assign w_offset = PTR_W'(g) - r_head;
        assign w_hit[g] = ({1'b0, w_offset} < r_count) &&
                          !((w_offset == '0) && (r_state == ST_ISSUE)) &&
                          (r_lines[g] == w_snoop_line);
    end

    assign w_merge_hit = |w_hit;
`else
    assign w_merge_hit = 1'b0;
`endif

    // Ready only looks at the current occupancy; a pop in the same cycle
    // does not free a slot early, which keeps ready off the pop path.
    assign w_ready = (r_count < CNT_W'(DEPTH)) | w_merge_hit;
    assign w_push  = snoop_valid & w_ready & ~w_merge_hit;
    assign w_pop   = (r_state == ST_ISSUE) & extern_inv_complete;

    // FIFO storage and pointers; push and pop may happen together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_lines[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_lines[r_tail] <= w_snoop_line;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. ISSUE always returns through IDLE after a complete,
    // so extern_inv is low for at least one cycle between requests; the tag
    // side would otherwise see a held-high request as already started.
    always_comb begin
        w_state_next = r_state;
        w_load_addr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((r_count != '0) || w_push) begin
                    w_state_next = ST_ISSUE;
                    w_load_addr  = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (extern_inv_complete) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Issue address is captured on entry to ISSUE and held stable until the
    // next request. An empty queue takes the line being pushed right now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inv_line <= '0;
        end else if (w_load_addr) begin
            r_inv_line <= (r_count != '0) ? r_lines[r_head] : w_snoop_line;
        end
    end

    assign snoop_ready = w_ready;
    assign extern_inv  = (r_state == ST_ISSUE);
    assign inv_addr    = {r_inv_line, {LINE_OFFSET_W{1'b0}}};
    assign inv_pending = (r_count != '0);

endmodule

// File: tb/tb_icache_inv_issuer.sv
// ---------------------------------------------------------------------------
// tb_icache_inv_issuer
//
// Directed bench for icache_inv_issuer (DEPTH=4, LINE_OFFSET_W=5). Inputs are
// driven on the falling clock edge and outputs are sampled there as well,
// half a cycle away from the rising edge the design uses.
// ---------------------------------------------------------------------------
module tb_icache_inv_issuer;

    logic        clk;
    logic        rstN;
    logic        snoopValid;
    logic [31:0] snoopAddr;
    logic        snoopReady;
    logic        externInv;
    logic [31:0] invAddr;
    logic        invComplete;
    logic        invPending;

    int errors;
    int checks;

    icache_inv_issuer #(
        .DEPTH        (4),
        .LINE_OFFSET_W(5)
    ) dut (
        .clk                (clk),
        .rst_n              (rstN),
        .snoop_valid        (snoopValid),
        .snoop_addr         (snoopAddr),
        .snoop_ready        (snoopReady),
        .extern_inv         (externInv),
        .inv_addr           (invAddr),
        .extern_inv_complete(invComplete),
        .inv_pending        (invPending)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges the sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Present one request for one rising edge; call at a falling edge with
    // snoop_ready known high.
    task automatic applyStimulus(input logic [31:0] addr);
        snoopValid = 1'b1;
        snoopAddr  = addr;
        @(negedge clk);
        snoopValid = 1'b0;
    endtask

    // Wait, bounded, for extern_inv to be high at a falling edge.
    task automatic waitIssue(input int budget, output bit ok, output logic [31:0] addr);
        ok   = 1'b0;
        addr = '0;
        for (int i = 0; i < budget; i++) begin
            if (externInv === 1'b1) begin
                ok   = 1'b1;
                addr = invAddr;
                break;
            end
            @(negedge clk);
        end
    endtask

    // One-cycle completion pulse.
    task automatic pulseComplete();
        invComplete = 1'b1;
        @(negedge clk);
        invComplete = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (externInv !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_extern_inv: got %b expected 0", externInv);
        end
        checks++;
        if (invAddr !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_inv_addr: got %h expected 00000000", invAddr);
        end
        checks++;
        if (invPending !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_inv_pending: got %b expected 0", invPending);
        end
        checks++;
        if (snoopReady !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_snoop_ready: got %b expected 1", snoopReady);
        end
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        applyStimulus(32'h0000_1234);
        checks++;
        if (externInv !== 1'b1) begin
            errors++; $display("[TB] FAIL single_rise: got %b expected 1", externInv);
        end
        checks++;
        if (invAddr !== 32'h0000_1220) begin
            errors++; $display("[TB] FAIL single_addr: got %h expected 00001220", invAddr);
        end
        checks++;
        if (invPending !== 1'b1) begin
            errors++; $display("[TB] FAIL single_pending: got %b expected 1", invPending);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (externInv !== 1'b1 || invAddr !== 32'h0000_1220) begin
            errors++; $display("[TB] FAIL single_hold: got %b/%h expected 1/00001220", externInv, invAddr);
        end
        pulseComplete();
        checks++;
        if (externInv !== 1'b0) begin
            errors++; $display("[TB] FAIL single_fall: got %b expected 0", externInv);
        end
        checks++;
        if (invPending !== 1'b0) begin
            errors++; $display("[TB] FAIL single_pending_clear: got %b expected 0", invPending);
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(32'h0000_0100);
        checks++;
        if (externInv !== 1'b1 || invAddr !== 32'h0000_0100) begin
            errors++; $display("[TB] FAIL b2b_first: got %b/%h expected 1/00000100", externInv, invAddr);
        end
        applyStimulus(32'h0000_0200);
        @(negedge clk);
        pulseComplete();
        checks++;
        if (externInv !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_gap: got %b expected 0", externInv);
        end
        checks++;
        if (invPending !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_gap_pending: got %b expected 1", invPending);
        end
        @(negedge clk);
        checks++;
        if (externInv !== 1'b1 || invAddr !== 32'h0000_0200) begin
            errors++; $display("[TB] FAIL b2b_second: got %b/%h expected 1/00000200", externInv, invAddr);
        end
        @(negedge clk);
        pulseComplete();
        checks++;
        if (externInv !== 1'b0 || invPending !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_done: got %b/%b expected 0/0", externInv, invPending);
        end
    endtask

    task automatic test_full();
        logic [31:0] expAddr [4];
        bit          ok;
        logic [31:0] got;
        expAddr = '{32'h0000_2000, 32'h0000_3000, 32'h0000_4000, 32'h0000_5000};
        applyStimulus(32'h0000_1000);
        applyStimulus(32'h0000_2000);
        applyStimulus(32'h0000_3000);
        applyStimulus(32'h0000_4000);
        checks++;
        if (externInv !== 1'b1 || invAddr !== 32'h0000_1000) begin
            errors++; $display("[TB] FAIL full_head: got %b/%h expected 1/00001000", externInv, invAddr);
        end
        snoopValid = 1'b1;
        snoopAddr  = 32'h0000_5000;
        #1;
        checks++;
        if (snoopReady !== 1'b0) begin
            errors++; $display("[TB] FAIL full_ready_low: got %b expected 0", snoopReady);
        end
        invComplete = 1'b1;
        #1;
        checks++;
        if (snoopReady !== 1'b0) begin
            errors++; $display("[TB] FAIL full_ready_with_pop: got %b expected 0", snoopReady);
        end
        @(negedge clk);
        invComplete = 1'b0;
        #1;
        checks++;
        if (snoopReady !== 1'b1) begin
            errors++; $display("[TB] FAIL full_ready_after_pop: got %b expected 1", snoopReady);
        end
        checks++;
        if (externInv !== 1'b0) begin
            errors++; $display("[TB] FAIL full_gap: got %b expected 0", externInv);
        end
        @(negedge clk);
        snoopValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            waitIssue(20, ok, got);
            checks++;
            if (!ok || got !== expAddr[k]) begin
                errors++; $display("[TB] FAIL full_order[%0d]: got %h expected %h", k, got, expAddr[k]);
            end
            pulseComplete();
        end
        checks++;
        if (invPending !== 1'b0) begin
            errors++; $display("[TB] FAIL full_drained: got %b expected 0", invPending);
        end
    endtask

    task automatic test_merge();
        logic [31:0] expQ [$];
        bit          ok;
        logic [31:0] got;
`ifdef ICACHE_INV_MERGE_EN
        expQ = '{32'h0000_0300, 32'h0000_0400, 32'h0000_0300};
`else
        expQ = '{32'h0000_0300, 32'h0000_0400, 32'h0000_0400, 32'h0000_0300};
`endif
        applyStimulus(32'h0000_0300);
        applyStimulus(32'h0000_0400);
        snoopValid = 1'b1;
        snoopAddr  = 32'h0000_0404;
        #1;
        checks++;
        if (snoopReady !== 1'b1) begin
            errors++; $display("[TB] FAIL merge_ready: got %b expected 1", snoopReady);
        end
        @(negedge clk);
        snoopAddr = 32'h0000_031C;
        @(negedge clk);
        snoopValid = 1'b0;
        foreach (expQ[k]) begin
            waitIssue(20, ok, got);
            checks++;
            if (!ok || got !== expQ[k]) begin
                errors++; $display("[TB] FAIL merge_order[%0d]: got %h expected %h", k, got, expQ[k]);
            end
            pulseComplete();
        end
        @(negedge clk);
        checks++;
        if (invPending !== 1'b0 || externInv !== 1'b0) begin
            errors++; $display("[TB] FAIL merge_drained: got %b/%b expected 0/0", invPending, externInv);
        end
    endtask

    task automatic test_wrap();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    int waited;
                    waited     = 0;
                    snoopValid = 1'b1;
                    snoopAddr  = 32'h0000_8000 + 32'(i) * 32'h40;
                    #1;
                    while (snoopReady !== 1'b1 && waited < 100) begin
                        @(negedge clk);
                        #1;
                        waited++;
                    end
                    checks++;
                    if (waited >= 100) begin
                        errors++; $display("[TB] FAIL wrap_push_timeout[%0d]: got ready=%b expected 1", i, snoopReady);
                    end
                    @(negedge clk);
                end
                snoopValid = 1'b0;
            end
            begin
                for (int k = 0; k < 10; k++) begin
                    bit          ok;
                    logic [31:0] got;
                    logic [31:0] expA;
                    expA = 32'h0000_8000 + 32'(k) * 32'h40;
                    waitIssue(200, ok, got);
                    checks++;
                    if (!ok || got !== expA) begin
                        errors++; $display("[TB] FAIL wrap_order[%0d]: got %h expected %h", k, got, expA);
                    end
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    pulseComplete();
                end
            end
        join
        @(negedge clk);
        checks++;
        if (invPending !== 1'b0) begin
            errors++; $display("[TB] FAIL wrap_drained: got %b expected 0", invPending);
        end
    endtask

    task automatic test_async_reset();
        bit          ok;
        logic [31:0] got;
        applyStimulus(32'h0000_0A00);
        applyStimulus(32'h0000_0B00);
        applyStimulus(32'h0000_0C00);
        checks++;
        if (externInv !== 1'b1) begin
            errors++; $display("[TB] FAIL areset_pre: got %b expected 1", externInv);
        end
        #2;
        rstN = 1'b0;
        #1;
        checks++;
        if (externInv !== 1'b0) begin
            errors++; $display("[TB] FAIL areset_extern_inv: got %b expected 0", externInv);
        end
        checks++;
        if (invPending !== 1'b0) begin
            errors++; $display("[TB] FAIL areset_pending: got %b expected 0", invPending);
        end
        checks++;
        if (invAddr !== 32'h0 || snoopReady !== 1'b1) begin
            errors++; $display("[TB] FAIL areset_addr_ready: got %h/%b expected 00000000/1", invAddr, snoopReady);
        end
        @(negedge clk);
        rstN = 1'b1;
        pulseComplete();
        checks++;
        if (externInv !== 1'b0 || invPending !== 1'b0) begin
            errors++; $display("[TB] FAIL areset_stray_complete: got %b/%b expected 0/0", externInv, invPending);
        end
        applyStimulus(32'h0000_0D00);
        waitIssue(20, ok, got);
        checks++;
        if (!ok || got !== 32'h0000_0D00) begin
            errors++; $display("[TB] FAIL areset_fresh: got %h expected 00000D00", got);
        end
        pulseComplete();
        checks++;
        if (invPending !== 1'b0 || externInv !== 1'b0) begin
            errors++; $display("[TB] FAIL areset_empty: got %b/%b expected 0/0", invPending, externInv);
        end
    endtask

    // Scenario sequence.
    initial begin
        errors      = 0;
        checks      = 0;
        rstN        = 1'b0;
        snoopValid  = 1'b0;
        snoopAddr   = 32'h0;
        invComplete = 1'b0;
        @(negedge clk);
        $display("[TB] starting");
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_merge();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
